ps2_keyboard_receiver: RTL and testbench

PS2_KEYBOARD_RECEIVER -- requirements
Module: ps2_keyboard_receiver

---
 rtl/ps2_keyboard_receiver.sv | 179 +++++++++++++++++
 tb/tb_ps2_keyboard_receiver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 clock, deframes
// 11-bit frames and folds E0/F0 prefixes into a single scancode event.
module ps2_keyboard_receiver #(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clkps2,
    input  logic       dataps2,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       released,
    output logic       kb_interrupt,
    output logic       frame_error,
    output logic [1:0] dbg_state
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic         clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic         filt_q, filt_d, filt_prev_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic         ext_pend_q, ext_pend_d, rel_pend_q, rel_pend_d;
    logic [7:0]   sc_q, sc_d;
    logic         ext_q, ext_d, rel_q, rel_d;
    logic         kb_q, kb_d, fe_q, fe_d;
    logic         fall_edge;
    logic         timeout;

    // One-cycle strobe in the first cycle the filtered clock reads low.
    assign fall_edge = filt_prev_q & ~filt_q;
    assign timeout   = (state_q != IDLE) && !fall_edge && (to_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            to_q        <= '0;
            ext_pend_q  <= 1'b0;
            rel_pend_q  <= 1'b0;
            sc_q        <= '0;
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            kb_q        <= 1'b0;
            fe_q        <= 1'b0;
        end else begin
            clk_s1_q    <= clkps2;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= dataps2;
            dat_s2_q    <= dat_s1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_q        <= to_d;
            ext_pend_q  <= ext_pend_d;
            rel_pend_q  <= rel_pend_d;
            sc_q        <= sc_d;
            ext_q       <= ext_d;
            rel_q       <= rel_d;
            kb_q        <= kb_d;
            fe_q        <= fe_d;
        end
    end

    // fcnt counts consecutive samples that disagree with the filtered level.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        to_d       = to_q;
        ext_pend_d = ext_pend_q;
        rel_pend_d = rel_pend_q;
        sc_d       = sc_q;
        ext_d      = ext_q;
        rel_d      = rel_q;
        kb_d       = 1'b0;
        fe_d       = 1'b0;

        if (state_q == IDLE || fall_edge) begin
            to_d = '0;
        end else if (to_q != TW'(TIMEOUT_CYCLES - 1)) begin
            to_d = to_q + 1'b1;
        end

        if (timeout) begin
            state_d = IDLE;
            to_d    = '0;
        end else if (fall_edge) begin
            case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (dat_s2_q && (^{shift_q, par_q})) begin
                        if (shift_q == 8'hE0) begin
                            ext_pend_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            rel_pend_d = 1'b1;
                        end else begin
                            sc_d       = shift_q;
                            ext_d      = ext_pend_q;
                            rel_d      = rel_pend_q;
                            kb_d       = 1'b1;
                            ext_pend_d = 1'b0;
                            rel_pend_d = 1'b0;
                        end
                    end else begin
                        fe_d       = 1'b1;
                        ext_pend_d = 1'b0;
                        rel_pend_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign scancode     = sc_q;
    assign extended     = ext_q;
    assign released     = rel_q;
    assign kb_interrupt = kb_q;
    assign frame_error  = fe_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Directed bench for ps2_keyboard_receiver: drives PS/2 frames and checks
// scancode/prefix outputs, pulse counts, errors, timeout and glitch rejection.
`timescale 1ns/1ps
module tb_ps2_keyboard_receiver;

    localparam int TO_CYC = 400;
    localparam int FLEN   = 8;
    localparam int HALF   = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clkps2 = 1'b1;
    logic       dataps2 = 1'b1;
    logic [7:0] scancode;
    logic       extended, released, kb_interrupt, frame_error;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;
    int kint_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;

    ps2_keyboard_receiver #(.TIMEOUT_CYCLES(TO_CYC), .FILTER_LEN(FLEN)) dut (
        .clk(clk), .reset(reset), .clkps2(clkps2), .dataps2(dataps2),
        .scancode(scancode), .extended(extended), .released(released),
        .kb_interrupt(kb_interrupt), .frame_error(frame_error), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (kb_interrupt === 1'b1) kint_cnt++;
        if (frame_error === 1'b1) ferr_cnt++;
        if (kb_interrupt === 1'b1 && frame_error === 1'b1) both_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        dataps2 = b;
        wait_cyc(HALF);
        clkps2 = 1'b0;
        wait_cyc(HALF);
        clkps2 = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic flip);
        return {1'b1, (~^d) ^ flip, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
        dataps2 = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip);
        send_bits(make_frame(d, flip), 11);
        wait_cyc(30);
    endtask

    task automatic check_out(input string name, input int k0, input int f0, input int exp_k,
                             input int exp_f, input logic [7:0] exp_sc, input logic exp_e,
                             input logic exp_r);
        total++;
        if ((kint_cnt - k0) !== exp_k) begin
            bad++; $display("FAIL %s_kint got=%0d exp=%0d", name, kint_cnt - k0, exp_k);
        end
        total++;
        if ((ferr_cnt - f0) !== exp_f) begin
            bad++; $display("FAIL %s_ferr got=%0d exp=%0d", name, ferr_cnt - f0, exp_f);
        end
        total++;
        if (scancode !== exp_sc) begin
            bad++; $display("FAIL %s_scancode got=%h exp=%h", name, scancode, exp_sc);
        end
        total++;
        if (extended !== exp_e) begin
            bad++; $display("FAIL %s_extended got=%b exp=%b", name, extended, exp_e);
        end
        total++;
        if (released !== exp_r) begin
            bad++; $display("FAIL %s_released got=%b exp=%b", name, released, exp_r);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cyc(5);
        total++;
        if ({kb_interrupt, frame_error} !== 2'b00) begin
            bad++; $display("FAIL reset_pulses got=%b exp=00", {kb_interrupt, frame_error});
        end
        total++;
        if (dbg_state !== 2'd0) begin
            bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
        end
        check_out("reset", kint_cnt, ferr_cnt, 0, 0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        wait_cyc(20);
    endtask

    task automatic test_make();
        int k0 = kint_cnt, f0 = ferr_cnt;
        send_frame(8'h1C, 1'b0);
        check_out("make_1c", k0, f0, 1, 0, 8'h1C, 1'b0, 1'b0);
    endtask

    task automatic test_release();
        int k0 = kint_cnt, f0 = ferr_cnt;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check_out("break_1c", k0, f0, 1, 0, 8'h1C, 1'b0, 1'b1);
    endtask

    task automatic test_extended();
        int k0 = kint_cnt, f0 = ferr_cnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check_out("ext_break_75", k0, f0, 1, 0, 8'h75, 1'b1, 1'b1);
        k0 = kint_cnt;
        send_frame(8'h1C, 1'b0);
        check_out("after_ext_1c", k0, f0, 1, 0, 8'h1C, 1'b0, 1'b0);
    endtask

    task automatic test_parity_error();
        int k0, f0;
        send_frame(8'h29, 1'b0);
        k0 = kint_cnt; f0 = ferr_cnt;
        send_frame(8'h1C, 1'b1);
        check_out("bad_parity", k0, f0, 0, 1, 8'h29, 1'b0, 1'b0);
        k0 = kint_cnt; f0 = ferr_cnt;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b1);
        send_frame(8'h1C, 1'b0);
        check_out("err_clears_f0", k0, f0, 1, 1, 8'h1C, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        int k0 = kint_cnt, f0 = ferr_cnt;
        send_bits(make_frame(8'h29, 1'b0), 6);
        total++;
        if (dbg_state !== 2'd1) begin
            bad++; $display("FAIL timeout_partial_state got=%0d exp=1", dbg_state);
        end
        wait_cyc(TO_CYC + 10);
        total++;
        if (dbg_state !== 2'd0) begin
            bad++; $display("FAIL timeout_idle_state got=%0d exp=0", dbg_state);
        end
        check_out("timeout_stall", k0, f0, 0, 0, 8'h1C, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0);
        check_out("timeout_then_29", k0, f0, 1, 0, 8'h29, 1'b0, 1'b0);
        k0 = kint_cnt;
        send_frame(8'hF0, 1'b0);
        send_bits(make_frame(8'h75, 1'b0), 6);
        wait_cyc(TO_CYC + 10);
        send_frame(8'h1C, 1'b0);
        check_out("timeout_keeps_f0", k0, f0, 1, 0, 8'h1C, 1'b0, 1'b1);
    endtask

    task automatic test_glitch();
        int k0 = kint_cnt, f0 = ferr_cnt;
        dataps2 = 1'b0;
        wait_cyc(10);
        clkps2 = 1'b0; wait_cyc(1); clkps2 = 1'b1;
        wait_cyc(20);
        total++;
        if (dbg_state !== 2'd0) begin
            bad++; $display("FAIL glitch1_state got=%0d exp=0", dbg_state);
        end
        clkps2 = 1'b0; wait_cyc(5); clkps2 = 1'b1;
        wait_cyc(20);
        total++;
        if (dbg_state !== 2'd0) begin
            bad++; $display("FAIL glitch5_state got=%0d exp=0", dbg_state);
        end
        dataps2 = 1'b1;
        wait_cyc(10);
        check_out("glitch", k0, f0, 0, 0, 8'h1C, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midframe();
        int k0, f0;
        send_bits(make_frame(8'h55, 1'b0), 4);
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(5);
        total++;
        if (dbg_state !== 2'd0) begin
            bad++; $display("FAIL midreset_state got=%0d exp=0", dbg_state);
        end
        k0 = kint_cnt; f0 = ferr_cnt;
        check_out("midreset_clear", k0, f0, 0, 0, 8'h00, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check_out("midreset_then_1c", k0, f0, 1, 0, 8'h1C, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int k0 = kint_cnt, f0 = ferr_cnt;
        send_bits(make_frame(8'h12, 1'b0), 11);
        send_bits(make_frame(8'h34, 1'b0), 11);
        wait_cyc(30);
        check_out("b2b", k0, f0, 2, 0, 8'h34, 1'b0, 1'b0);
        total++;
        if (both_cnt !== 0) begin
            bad++; $display("FAIL both_pulses got=%0d exp=0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_release();
        test_extended();
        test_parity_error();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
